key_expansion_inverse: RTL
==========================

# key_expansion_inverse

Iterative AES-128 inverse key scheduler for the decryption datapath. It accepts the final round key (round Nr) and walks the schedule backwards, one round per cycle. It emits round keys Nr, Nr-1, … 0 on a valid/ready stream, which gives the inverse-cipher rounds their keys in consumption order without storing the full forward schedule.

## Interface
- `KEY_LENGTH`, 128: round key width in bits; only 128 is supported.
- `WORD_LENGTH`, 32: schedule word width.
- `Nr`, 10: number of rounds; the first beat is round Nr.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `i_valid`  in  1  request: `last_key` is valid.
- `i_ready`  out  1  block can accept a request; high only in IDLE.
- `last_key`  in  128  round-Nr key. w0 = [127:96], w1 = [95:64], w2 = [63:32], w3 = [31:0].
- `o_valid`  out  1  `round_key` / `o_round` valid.
- `o_ready`  in  1  consumer accepts the current beat.
- `round_key`  out  128  current round key, same word order as `last_key`.
- `o_round`  out  4  round index of the current beat, Nr down to 0.
- `o_last`  out  1  high with the round-0 beat only.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - `i_ready` = 1, `o_valid` = 0.
  - On `i_valid`: `key_reg` <= `last_key`, `o_round` <= Nr, go to EMIT.
- EMIT:
  - `o_valid` = 1, `round_key` = `key_reg`, `o_last` = (`o_round` == 0).
  - A beat transfers when `o_valid` && `o_ready`.
  - Transfer with `o_round` > 0: `key_reg` <= inv(`key_reg`, `o_round`), `o_round` <= `o_round` - 1.
  - Transfer with `o_round` == 0: go to IDLE.
  - No transfer: `key_reg`, `o_round` and `o_last` hold; `round_key` is stable.
- inv(K, r), with K = {w0, w1, w2, w3} (all XOR, 32-bit):
  - p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon(r).
  - Result = {p0, p1, p2, p3}.
- RotWord({a, b, c, d}) = {b, c, d, a}. SubWord applies the forward AES S-box to each byte.
- Rcon(r) = {rc, 24'h0}, where rc for r = 1..10 is 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- The S-box is implemented in-block: 4 combinational 256-entry lookups. The Rcon lookup is a combinational function of `o_round`.
- `i_valid` outside IDLE is ignored, with no queuing. A new request is accepted only after the round-0 beat has transferred.

## Timing
- Reset asserted (`reset` = 0), async:
  - State = IDLE; `key_reg` = 0, so `round_key` = 0.
  - `o_round` = 0, `o_valid` = 0, `o_last` = 0, `i_ready` = 1.
- Reset asserted mid-sequence: the sequence is aborted immediately with no further beats. Outputs take their reset values.
- Request accepted at edge T: first beat (round Nr) is valid after T, in cycle T+1.
- With `o_ready` held high: one beat per cycle, Nr+1 = 11 beats in cycles T+1..T+11. `i_ready` rises in cycle T+12.
- Each backpressure cycle (`o_ready` = 0 while `o_valid`) adds exactly one cycle. `round_key` must not change while stalled.
- Back-to-back requests: IDLE lasts at least one cycle between sequences, so the minimum request period is Nr+2 = 12 cycles.
- Inverse round logic is single-cycle combinational between registers: one S-box level plus XORs.

## Configuration
- `KEY_EXP_INV_ZEROIZE_EN`:
  - Defined: on the edge that transfers the round-0 beat, `key_reg` is cleared to 0. `round_key` reads 0 whenever `o_valid` = 0, so no key material lingers in IDLE.
  - Not defined: after completion, `key_reg` and `round_key` retain the round-0 key until the next request or reset.

## Test plan
- FIPS-197 A.1, `o_ready` = 1: `last_key` = d014f9a8c9ee2589e13f0cc8b6630ca6. Required:
  - round 10 beat = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - round 9 = ac7766f319fadc2128d12941575c006e;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c with `o_last` = 1.
  - 11 beats total; `i_ready` high in cycle T+12.
- Backpressure: same key, `o_ready` toggled randomly 50%. Required: identical 11-key sequence; `round_key` and `o_round` stable during every stall; `o_last` only on round 0.
- Ignored request: pulse `i_valid` with a different key during beat 5. Required: sequence unchanged, `i_ready` stays 0.
- Async reset at round 6 (mid-cycle, no clock edge): `o_valid`, `o_round`, `o_last` and `round_key` go to 0 immediately; `i_ready` = 1. A subsequent request restarts from round 10.
- Round trip: random 128-bit key K0 expanded by the forward scheduler to round 10, then fed here. Required: round-0 beat == K0 for 1000 random keys.
- Zeroize: with `KEY_EXP_INV_ZEROIZE_EN` defined, `round_key` = 0 in the cycle after the round-0 transfer. Without it, `round_key` = 2b7e1516… (the round-0 key) is retained.

Source files
------------

// File: rtl/key_expansion_inverse.sv
// Iterative AES-128 inverse key scheduler: takes round key Nr and streams keys Nr..0, one per beat.
// Optional KEY_EXP_INV_ZEROIZE_EN clears the key register once the round-0 beat has been consumed.
module key_expansion_inverse #(
    parameter int KEY_LENGTH  = 128,
    parameter int WORD_LENGTH = 32,
    parameter int Nr          = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [KEY_LENGTH-1:0] last_key,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [KEY_LENGTH-1:0] round_key,
    output logic [3:0]            o_round,
    output logic                  o_last,
    output logic [0:0]            fsm_state
);

    // Handshakes: a request is taken when i_valid && i_ready; a beat moves when o_valid && o_ready.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    logic [0:0]            state;
    logic [KEY_LENGTH-1:0] key_reg;
    logic [WORD_LENGTH-1:0] w0, w1, w2, w3;
    logic [WORD_LENGTH-1:0] p0, p1, p2, p3;
    logic [WORD_LENGTH-1:0] rot, sub;
    logic [KEY_LENGTH-1:0] prev_key;
    logic                  xfer;

    assign {w0, w1, w2, w3} = key_reg;

    // Undo one forward step: later words are recovered first, then w0 from the recovered w3.
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};
    assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    assign p0  = w0 ^ sub ^ {rcon(o_round), 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    assign o_valid   = (state == EMIT);
    assign i_ready   = (state == IDLE);
    assign o_last    = o_valid && (o_round == 4'd0);
    assign xfer      = o_valid && o_ready;
    assign fsm_state = state;

`ifdef KEY_EXP_INV_ZEROIZE_EN
    assign round_key = o_valid ? key_reg : '0;
`else
    assign round_key = key_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            key_reg <= '0;
            o_round <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        key_reg <= last_key;
                        o_round <= 4'(Nr);
                        state   <= EMIT;
                    end
                end
                default: begin
                    if (xfer) begin
                        if (o_round != 4'd0) begin
                            key_reg <= prev_key;
                            o_round <= o_round - 4'd1;
                        end else begin
                            state <= IDLE;
`ifdef KEY_EXP_INV_ZEROIZE_EN
                            key_reg <= '0;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule
